// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared shift op, state encodings and widths
package shift_sequencer_pkg;

  localparam int SHAMT_W = 5;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] IDX_TOP = 3'd4;

  typedef enum logic [1:0] {
    SHIFT_SLL     = 2'b00,
    SHIFT_SRL     = 2'b01,
    SHIFT_SRA     = 2'b10,
    SHIFT_ILLEGAL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one power-of-two shift stage, shared across all cycles
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             enable_i,
  input  shift_op_e        op_i,
  output logic [WIDTH-1:0] data_o
);

  logic [5:0] amt;

  assign amt = 6'd1 << idx_i;

  always_comb begin
    data_o = data_i;
    if (enable_i) begin
      case (op_i)
        SHIFT_SLL: data_o = data_i << amt;
        SHIFT_SRL: data_o = data_i >> amt;
        SHIFT_SRA: data_o = $signed(data_i) >>> amt;
        default:   data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift controller, one stage per cycle MSB first
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0,
  parameter int WIDTH      = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  shift_op_e          op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_err_q, out_err_d;

  logic               accept;
  logic               in_illegal;
  logic               in_skip;
  logic               shift_last;
  logic [SHAMT_W-1:0] low_mask;
  logic [WIDTH-1:0]   stage_out;

  assign accept     = in_valid && (state_q == IDLE);
  assign in_illegal = (in_op == SHIFT_ILLEGAL);
  assign in_skip    = in_illegal || (EARLY_EXIT && (in_shamt == '0));
  assign low_mask   = (SHAMT_W'(1) << idx_q) - SHAMT_W'(1);
  assign shift_last = (idx_q == '0) || (EARLY_EXIT && ((shamt_q & low_mask) == '0));

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .data_i   (data_q),
    .idx_i    (idx_q),
    .enable_i (shamt_q[idx_q]),
    .op_i     (op_q),
    .data_o   (stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_skip ? DONE : SHIFT;
      SHIFT:   if (shift_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = out_data_q;
    out_err   = out_err_q;
  end

  // Result registers only load on entry to DONE so they hold steady in IDLE/SHIFT.
  always_comb begin
    idx_d      = idx_q;
    shamt_d    = shamt_q;
    op_d       = op_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (state_q == IDLE && accept) begin
      idx_d   = IDX_TOP;
      shamt_d = in_shamt;
      op_d    = shift_op_e'(in_op);
      data_d  = in_data;
      if (in_skip) begin
        out_data_d = in_data;
        out_err_d  = in_illegal;
      end
    end else if (state_q == SHIFT) begin
      data_d = stage_out;
      if (shift_last) begin
        out_data_d = stage_out;
        out_err_d  = 1'b0;
      end else begin
        idx_d = idx_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= IDX_TOP;
      shamt_q    <= '0;
      op_q       <= SHIFT_SLL;
      data_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      shamt_q    <= shamt_d;
      op_q       <= op_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench, unit 0 fixed latency, unit 1 early exit
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;
  logic [31:0] in_data  [2];
  logic [4:0]  in_shamt [2];
  logic [1:0]  in_op    [2];
  wire  [1:0]  in_ready;
  wire  [1:0]  out_valid;
  wire  [1:0]  out_err;
  wire  [1:0]  busy;
  wire  [31:0] out_data [2];

  always #5 clock = ~clock;

  shift_sequencer #(.EARLY_EXIT(1'b0), .WIDTH(32)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_shamt(in_shamt[0]), .in_op(in_op[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_err(out_err[0]), .busy(busy[0])
  );

  shift_sequencer #(.EARLY_EXIT(1'b1), .WIDTH(32)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_shamt(in_shamt[1]), .in_op(in_op[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_err(out_err[1]), .busy(busy[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          infl [2];
  bit          pv   [2];
  logic [31:0] held_data [2];
  logic        held_err  [2];
  bit          rr   [2];

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: whole shift in one step, latency from the stage-count rule.
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] s,
                                 input logic [1:0] op, input bit ee);
    exp_t e;
    int   k;
    e.err = (op == 2'b11);
    case (op)
      2'b00:   e.data = d << s;
      2'b01:   e.data = d >> s;
      2'b10:   e.data = $signed(d) >>> s;
      default: e.data = d;
    endcase
    k = 0;
    for (int i = 4; i >= 0; i--) if (s[i]) k = i;
    if (op == 2'b11 || (ee && s == 5'd0)) e.lat = 1;
    else if (!ee)                         e.lat = 6;
    else                                  e.lat = 6 - k;
    e.acc = 0;
    return e;
  endfunction

  task automatic mon(input int u);
    exp_t e;
    bit   have;
    string tag;
    tag = $sformatf("u%0d", u);
    chk({tag, "_in_ready"}, 32'(in_ready[u]), 32'(!infl[u]));
    chk({tag, "_busy"}, 32'(busy[u]), 32'(infl[u]));
    if (!infl[u]) chk({tag, "_out_valid_idle"}, 32'(out_valid[u]), 32'd0);
    if (out_valid[u] && !pv[u]) begin
      have = 1'b0;
      if (u == 0) begin if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end end
      else        begin if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end end
      chk({tag, "_expected_pending"}, 32'(have), 32'd1);
      if (have) begin
        chk({tag, "_out_data"}, out_data[u], e.data);
        chk({tag, "_out_err"}, 32'(out_err[u]), 32'(e.err));
        chk({tag, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
      held_data[u] = out_data[u];
      held_err[u]  = out_err[u];
    end else if (out_valid[u]) begin
      chk({tag, "_hold_data"}, out_data[u], held_data[u]);
      chk({tag, "_hold_err"}, 32'(out_err[u]), 32'(held_err[u]));
    end
    pv[u] = out_valid[u];
    if (out_valid[u] && out_ready[u]) infl[u] = 1'b0;
    if (in_valid[u] && in_ready[u]) begin
      e = model(in_data[u], in_shamt[u], in_op[u], u == 1);
      e.acc = cyc + 1;
      if (u == 0) q0.push_back(e); else q1.push_back(e);
      infl[u] = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      for (int u = 0; u < 2; u++) begin
        infl[u] = 1'b0;
        pv[u]   = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) mon(u);
    end
  end

  always @(posedge clock) begin
    #1;
    for (int u = 0; u < 2; u++) if (rr[u]) out_ready[u] = ($urandom_range(3, 0) != 0);
  end

  task automatic issue(input int u, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    in_data[u]  = d;
    in_shamt[u] = s;
    in_op[u]    = op;
    in_valid[u] = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      if (in_ready[u]) ok = 1'b1;
    end
    chk($sformatf("u%0d_accept_timeout", u), 32'(ok), 32'd1);
    @(posedge clock);
    #1;
    in_valid[u] = 1'b0;
    in_data[u]  = $urandom;
    in_shamt[u] = 5'($urandom_range(31, 0));
    in_op[u]    = 2'($urandom_range(3, 0));
  endtask

  task automatic wait_idle(input int u);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clock);
      #1;
      if (in_ready[u]) ok = 1'b1;
    end
    chk($sformatf("u%0d_idle_timeout", u), 32'(ok), 32'd1);
  endtask

  initial begin
    exp_t e;
    bit   ok;
    reset_n   = 1'b1;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    for (int u = 0; u < 2; u++) begin
      in_data[u]  = '0;
      in_shamt[u] = '0;
      in_op[u]    = '0;
      rr[u]       = 1'b0;
    end
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_in_ready", 32'(in_ready[u]), 32'd1);
      chk("reset_out_valid", 32'(out_valid[u]), 32'd0);
      chk("reset_out_data", out_data[u], 32'd0);
      chk("reset_out_err", 32'(out_err[u]), 32'd0);
      chk("reset_busy", 32'(busy[u]), 32'd0);
    end
    reset_n   = 1'b1;
    out_ready = 2'b11;
    @(posedge clock);
    #1;

    issue(0, 32'h0000_0001, 5'd31, 2'b00);
    issue(0, 32'h8000_00F0, 5'd4, 2'b10);
    issue(0, 32'h8000_00F0, 5'd4, 2'b01);
    issue(1, 32'hFFFF_FFFF, 5'd16, 2'b01);
    issue(1, 32'hFFFF_FFFF, 5'd0, 2'b01);
    issue(1, 32'h1234_5678, 5'd5, 2'b11);
    issue(1, 32'h0000_000F, 5'd3, 2'b00);
    issue(0, 32'h1234_5678, 5'd5, 2'b11);
    issue(0, 32'hC000_0000, 5'd1, 2'b10);
    wait_idle(0);
    wait_idle(1);

    // Hold the result for 10 cycles, then release with the next request already waiting.
    out_ready[0] = 1'b0;
    issue(0, 32'hA5A5_0F0F, 5'd7, 2'b10);
    e  = model(32'hA5A5_0F0F, 5'd7, 2'b10, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clock);
      #1;
      if (out_valid[0]) ok = 1'b1;
    end
    chk("bp_valid_timeout", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("bp_out_data", out_data[0], e.data);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    issue(0, 32'h0000_0005, 5'd2, 2'b00);
    wait_idle(0);

    rr[0] = 1'b1;
    rr[1] = 1'b1;
    fork
      begin
        repeat (150) issue(0, $urandom, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)));
      end
      begin
        repeat (150) issue(1, $urandom, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)));
      end
    join
    rr[0] = 1'b0;
    rr[1] = 1'b0;
    @(posedge clock);
    #2;
    out_ready = 2'b11;
    wait_idle(0);
    wait_idle(1);

    issue(0, 32'h0000_00FF, 5'd4, 2'b00);
    wait_idle(0);
    chk("pre_reset_out_data", out_data[0], 32'h0000_0FF0);
    issue(0, 32'h0000_0001, 5'd31, 2'b00);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("mid_shift_busy", 32'(busy[0]), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_out_valid", 32'(out_valid[0]), 32'd0);
    chk("async_out_data", out_data[0], 32'd0);
    chk("async_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    issue(0, 32'h0000_0003, 5'd1, 2'b00);
    wait_idle(0);
    chk("post_reset_out_data", out_data[0], 32'h0000_0006);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
